// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler for a shared 4:1 select mux.
// Ports: clk, rst_n (async, active-low), req[3:0], data[4*DW-1:0],
//   urgent (only with MUX_SCHED_URGENT_EN), gnt[3:0], s[1:0], y[DW-1:0],
//   y_valid, busy.
// Parameters: DW data width, HOLD max consecutive cycles per grant slot.
// Optional feature macro: MUX_SCHED_URGENT_EN adds urgent preemption for
//   requester 0.
module mux_rr_scheduler #(
    parameter int DW   = 2,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] data,
`ifdef MUX_SCHED_URGENT_EN
    input  logic            urgent,
`endif
    output logic [3:0]      gnt,
    output logic [1:0]      s,
    output logic [DW-1:0]   y,
    output logic            y_valid,
    output logic            busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [DW-1:0]   y_q, y_d;
    logic            y_valid_q, y_valid_d;

    logic [DW-1:0]   lane [4];
    logic [2:0]      pick;
    logic            rel;
    logic            urg;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane[i] = data[i*DW +: DW];
    end

`ifdef MUX_SCHED_URGENT_EN
    assign urg = urgent & req[0];
`else
    assign urg = 1'b0;
`endif

    // Bit 2 flags a winner; bits 1:0 give its index. Scanning from the
    // far end backwards lets the nearest requester after base overwrite.
    function automatic logic [2:0] rr_pick(
        input logic [1:0] base,
        input logic [3:0] r
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // In GRANT last_q always equals the owner, so one search serves both.
    assign pick = rr_pick(last_q, req);
    assign rel  = ~req[owner_q] | (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (urg) begin
                    state_d = GRANT;
                    owner_d = 2'd0;
                    last_d  = 2'd0;
                    cnt_d   = '0;
                end else if (pick[2]) begin
                    state_d = GRANT;
                    owner_d = pick[1:0];
                    last_d  = pick[1:0];
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (urg && owner_q != 2'd0) begin
                    owner_d = 2'd0;
                    last_d  = 2'd0;
                    cnt_d   = '0;
                end else if (rel) begin
                    // A sole requester whose slot expires is found again
                    // here, so its grant continues without a gap.
                    if (pick[2]) begin
                        owner_d = pick[1:0];
                        last_d  = pick[1:0];
                    end else begin
                        state_d = IDLE;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        gnt_d     = '0;
        y_d       = y_q;
        y_valid_d = (state_q == GRANT);
        if (state_d == GRANT) begin
            gnt_d = 4'b0001 << owner_d;
        end
        if (state_q == GRANT) begin
            y_d = lane[owner_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            gnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign s       = owner_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler (DW=2, HOLD=4).
// Directed scenarios followed by randomized traffic and reset pulses.
module tb_mux_rr_scheduler;

    localparam int DW   = 2;
    localparam int HOLD = 4;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [4*DW-1:0] data;
    logic            urgent;
    logic [3:0]      gnt;
    logic [1:0]      s;
    logic [DW-1:0]   y;
    logic            y_valid;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]    gnt;
        logic [1:0]    s;
        logic [DW-1:0] y;
        logic          yv;
        logic          busy;
    } exp_t;

    exp_t sbq[$];

    mux_rr_scheduler #(
        .DW  (DW),
        .HOLD(HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .data   (data),
`ifdef MUX_SCHED_URGENT_EN
        .urgent (urgent),
`endif
        .gnt    (gnt),
        .s      (s),
        .y      (y),
        .y_valid(y_valid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: who holds the mux, who was served last, and how
    // long the current slot has lasted.
    bit            m_busy  = 0;
    int            m_owner = 0;
    int            m_last  = 3;
    int            m_cnt   = 0;
    logic [DW-1:0] m_y     = '0;
    logic          m_yv    = 0;

    function automatic int next_winner(int after, logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit urg_now();
`ifdef MUX_SCHED_URGENT_EN
        return urgent && req[0];
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 3;
        m_cnt   = 0;
        m_y     = '0;
        m_yv    = 0;
    endtask

    task automatic model_step();
        int   w;
        exp_t e;
        if (m_busy) m_y = data[m_owner*DW +: DW];
        m_yv = m_busy;
        if (!m_busy) begin
            w = urg_now() ? 0 : next_winner(m_last, req);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_last  = w;
                m_cnt   = 0;
            end
        end else if (urg_now() && m_owner != 0) begin
            m_owner = 0;
            m_last  = 0;
            m_cnt   = 0;
        end else if (!req[m_owner] || m_cnt == HOLD - 1) begin
            w = next_winner(m_owner, req);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
            end else begin
                m_busy = 0;
            end
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        e.gnt  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        e.s    = 2'(m_owner);
        e.y    = m_y;
        e.yv   = m_yv;
        e.busy = m_busy;
        sbq.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("gnt", 8'(gnt), 8'(e.gnt));
                chk("s", 8'(s), 8'(e.s));
                chk("y", 8'(y), 8'(e.y));
                chk("y_valid", 8'(y_valid), 8'(e.yv));
                chk("busy", 8'(busy), 8'(e.busy));
                chk("gnt_onehot0", 8'($countones(gnt) <= 1), 8'd1);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [7:0] d,
                         input logic u);
        req    = r;
        data   = d;
        urgent = u;
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_gnt"}, 8'(gnt), 8'h0);
        chk({nm, "_s"}, 8'(s), 8'h0);
        chk({nm, "_y"}, 8'(y), 8'h0);
        chk({nm, "_yv"}, 8'(y_valid), 8'h0);
        chk({nm, "_busy"}, 8'(busy), 8'h0);
    endtask

    // Called right after a negedge; the pulse ends before the next posedge.
    task automatic rst_pulse(input string nm);
        #2 rst_n = 1'b0;
        #1 chk_cleared(nm);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        rst_n  = 1'b0;
        req    = '0;
        data   = '0;
        urgent = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;
        repeat (3) drive(4'b0000, 8'($urandom), 1'b0);
        chk_cleared("idle_after_reset");

        // Single requester 2 with data[5:4]=11.
        d = 8'($urandom) | 8'b0011_0000;
        drive(4'b0100, d, 1'b0);
        chk("single_gnt_e1", 8'(gnt), 8'h4);
        chk("single_s_e1", 8'(s), 8'h2);
        d = 8'($urandom) | 8'b0011_0000;
        drive(4'b0100, d, 1'b0);
        chk("single_y_e2", 8'(y), 8'h3);
        chk("single_yv_e2", 8'(y_valid), 8'h1);
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom) | 8'b0011_0000;
            drive(4'b0100, d, 1'b0);
            chk("single_gnt_cont", 8'(gnt), 8'h4);
        end
        drive(4'b0000, 8'($urandom), 1'b0);
        chk("single_drop_busy", 8'(busy), 8'h0);

        // Full contention from a fresh reset.
        rst_pulse("rst_pre_contention");
        for (int i = 0; i < 20; i++) begin
            drive(4'b1111, 8'($urandom), 1'b0);
            chk("contention_gnt", 8'(gnt), 8'(4'b0001 << ((i / 4) % 4)));
        end

        // Early release of owner 1 hands straight to owner 3.
        rst_pulse("rst_pre_early");
        drive(4'b1010, 8'($urandom), 1'b0);
        drive(4'b1010, 8'($urandom), 1'b0);
        chk("early_owner1", 8'(gnt), 8'h2);
        drive(4'b1000, 8'($urandom), 1'b0);
        chk("early_handover", 8'(gnt), 8'h8);

        // Reset while owner 2 holds the grant.
        drive(4'b0100, 8'($urandom), 1'b0);
        repeat (3) drive(4'b0100, 8'($urandom), 1'b0);
        chk("pre_midrst_gnt", 8'(gnt), 8'h4);
        rst_pulse("midrst");
        drive(4'b1111, 8'($urandom), 1'b0);
        chk("post_midrst_gnt", 8'(gnt), 8'h1);

`ifdef MUX_SCHED_URGENT_EN
        rst_pulse("rst_pre_urgent");
        drive(4'b0100, 8'($urandom), 1'b0);
        drive(4'b0100, 8'($urandom), 1'b0);
        drive(4'b0101, 8'($urandom), 1'b1);
        chk("urgent_preempt", 8'(gnt), 8'h1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0101, 8'($urandom), 1'b0);
            chk("urgent_slot", 8'(gnt), 8'h1);
        end
        drive(4'b0101, 8'($urandom), 1'b0);
        chk("urgent_after", 8'(gnt), 8'h4);
`endif

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 4'($urandom);
            if ($urandom_range(0, 99) == 0) rst_pulse("rand_rst");
            drive(r, 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
